// File: rtl/wd_sector_bridge_pkg.sv
// Shared definitions for the WD1770 sector bridge: FSM state encodings and
// bit positions inside the controller's dsr command word and dcr status word.
package wd_bridge_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DECODE   = 3'd1;
  localparam logic [2:0] RD_XFER  = 3'd2;
  localparam logic [2:0] WR_XFER  = 3'd3;
  localparam logic [2:0] ACK      = 3'd4;
  localparam logic [2:0] ACK_WAIT = 3'd5;

  localparam int DSR_ACKACK = 16;
  localparam int DSR_RD1    = 17;
  localparam int DSR_RD0    = 18;
  localparam int DSR_WR1    = 20;
  localparam int DSR_WR0    = 21;
  localparam int DCR_ERR    = 3;
  localparam int DCR_FIN    = 4;

endpackage

// File: rtl/wd_sector_bridge_if.sv
// Bus bundle between the WD1770 ctrl-module side, the bridge and the block store.
// The bridge uses the master modport; the controller/storage environment uses slave.
interface wd_sector_bridge_if;
  logic [31:0] dsr;
  logic [31:0] dcr;
  logic [7:0]  dd0in;
  logic        dd0inclk;
  logic [7:0]  dd0out;
  logic        dd0outclk;
  logic [21:0] blk_lba;
  logic        blk_rd;
  logic        blk_wr;
  logic [7:0]  blk_rdata;
  logic        blk_rvalid;
  logic [7:0]  blk_wdata;
  logic        blk_wvalid;
  logic        blk_wready;
  logic        blk_done;
  logic        blk_err;
  logic        busy;

  modport master (
    input  dsr, dd0out, blk_rdata, blk_rvalid, blk_wready, blk_done, blk_err,
    output dcr, dd0in, dd0inclk, dd0outclk, blk_lba, blk_rd, blk_wr,
    output blk_wdata, blk_wvalid, busy
  );

  modport slave (
    output dsr, dd0out, blk_rdata, blk_rvalid, blk_wready, blk_done, blk_err,
    input  dcr, dd0in, dd0inclk, dd0outclk, blk_lba, blk_rd, blk_wr,
    input  blk_wdata, blk_wvalid, busy
  );
endinterface

// File: rtl/wd_sector_bridge_chs_to_lba.sv
// Combinational CHS-to-LBA mapper with range check; kept standalone so a later
// format/track engine can share the same disk-image geometry.
module wd_chs_to_lba #(
  parameter int SECT_PER_TRK = 10,
  parameter int NUM_TRK      = 80,
  parameter int DRIVE1_BASE  = 1600
) (
  input  logic [4:0]  sect_i,
  input  logic [6:0]  trk_i,
  input  logic        side_i,
  input  logic        drive_i,
  output logic [21:0] lba_o,
  output logic        valid_o
);

  logic [21:0] base;
  logic [21:0] trackSide;

  // {trk, side} is trk*2+side; sectors are numbered from 1 on disk
  always_comb begin
    base      = drive_i ? 22'(DRIVE1_BASE) : 22'd0;
    trackSide = {14'd0, trk_i, side_i};
    lba_o     = base + trackSide * 22'(SECT_PER_TRK) + {17'd0, sect_i} - 22'd1;
    valid_o   = (sect_i != 5'd0) && (int'(sect_i) <= SECT_PER_TRK) &&
                (int'(trk_i) < NUM_TRK);
  end

endmodule

// File: rtl/wd_sector_bridge.sv
// WD1770 ctrl-module to 512-byte block-storage bridge: decodes sector commands,
// streams one sector per command and acknowledges via dcr. Option: WD_BRIDGE_TIMEOUT_EN.
module wd_sector_bridge
  import wd_bridge_pkg::*;
#(
  parameter int SECT_PER_TRK = 10,
  parameter int NUM_TRK      = 80,
  parameter int DRIVE1_BASE  = 1600,
  parameter int SECT_BYTES   = 512
) (
  input logic               clk,
  input logic               rstn,
  wd_sector_bridge_if.master bus
);

  localparam int CW = $clog2(SECT_BYTES + 1);
  localparam logic [CW-1:0] FULL = CW'(SECT_BYTES);

  logic [2:0]    state_q, state_d;
  logic          rdReqPrev_q, wrReqPrev_q;
  logic          isRead_q, isRead_d;
  logic          drive_q, drive_d;
  logic [4:0]    sect_q, sect_d;
  logic [6:0]    trk_q, trk_d;
  logic          side_q, side_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_q, abort_d;
  logic          dcrFin_q, dcrFin_d;
  logic          dcrErr_q, dcrErr_d;
  logic [7:0]    dd0in_q, dd0in_d;
  logic          dd0inclk_q, dd0inclk_d;
  logic          dd0outclk_q, dd0outclk_d;
  logic          blkRd_q, blkRd_d;
  logic          blkWr_q, blkWr_d;
  logic          blkWvalid_q, blkWvalid_d;
  logic [21:0]   blkLba_q, blkLba_d;
  logic [7:0]    blkWdata_q, blkWdata_d;

  logic          rdReq, wrReq, rdStart, wrStart;
  logic          byteMoved, timeout, finish, errNext;
  logic [21:0]   mapLba;
  logic          mapValid;
  logic          unusedDsr;

  assign rdReq     = bus.dsr[DSR_RD0] | bus.dsr[DSR_RD1];
  assign wrReq     = bus.dsr[DSR_WR0] | bus.dsr[DSR_WR1];
  assign rdStart   = rdReq && !rdReqPrev_q;
  assign wrStart   = wrReq && !wrReqPrev_q;
  assign unusedDsr = ^{bus.dsr[31:22], bus.dsr[19], bus.dsr[15:13]};
  assign byteMoved = ((state_q == RD_XFER) && bus.blk_rvalid && (cnt_q < FULL)) ||
                     ((state_q == WR_XFER) && blkWvalid_q && bus.blk_wready);

  wd_chs_to_lba #(
    .SECT_PER_TRK(SECT_PER_TRK),
    .NUM_TRK     (NUM_TRK),
    .DRIVE1_BASE (DRIVE1_BASE)
  ) u_map (
    .sect_i (sect_q),
    .trk_i  (trk_q),
    .side_i (side_q),
    .drive_i(drive_q),
    .lba_o  (mapLba),
    .valid_o(mapValid)
  );

`ifdef WD_BRIDGE_TIMEOUT_EN
  logic [23:0] wdog_q, wdog_d;
  logic        inXfer;

  assign inXfer  = (state_q == RD_XFER) || (state_q == WR_XFER);
  assign timeout = inXfer && (wdog_q == 24'hFF_FFFF);
  assign wdog_d  = (!inXfer || byteMoved) ? 24'd0 : wdog_q + 24'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wdog_q <= 24'd0;
    else       wdog_q <= wdog_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    isRead_d    = isRead_q;
    drive_d     = drive_q;
    sect_d      = sect_q;
    trk_d       = trk_q;
    side_d      = side_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    dcrFin_d    = dcrFin_q;
    dcrErr_d    = dcrErr_q;
    dd0in_d     = dd0in_q;
    dd0inclk_d  = 1'b0;
    dd0outclk_d = 1'b0;
    blkRd_d     = blkRd_q;
    blkWr_d     = blkWr_q;
    blkWvalid_d = blkWvalid_q;
    blkLba_d    = blkLba_q;
    blkWdata_d  = blkWdata_q;
    finish      = 1'b0;
    errNext     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdStart || wrStart) begin
          state_d  = DECODE;
          isRead_d = rdStart;
          drive_d  = rdStart ? !bus.dsr[DSR_RD0] : !bus.dsr[DSR_WR0];
          sect_d   = bus.dsr[4:0];
          trk_d    = bus.dsr[11:5];
          side_d   = bus.dsr[12];
        end
      end
      DECODE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        if (!mapValid) begin
          state_d  = ACK;
          dcrFin_d = 1'b1;
          dcrErr_d = 1'b1;
        end else begin
          blkLba_d = mapLba;
          blkRd_d  = isRead_q;
          blkWr_d  = !isRead_q;
          state_d  = isRead_q ? RD_XFER : WR_XFER;
        end
      end
      RD_XFER: begin
        if (!rdReq) abort_d = 1'b1;
        if (bus.blk_rvalid && (cnt_q < FULL)) begin
          dd0in_d    = bus.blk_rdata;
          dd0inclk_d = 1'b1;
          cnt_d      = cnt_q + CW'(1);
        end
        if (bus.blk_done || timeout) begin
          blkRd_d = 1'b0;
          finish  = 1'b1;
          errNext = timeout || bus.blk_err || (cnt_d != FULL);
        end
      end
      WR_XFER: begin
        // The FIFO is show-ahead, so dd0out is latched in the same cycle as the pop strobe
        if (!wrReq) abort_d = 1'b1;
        if (dd0outclk_q) begin
          blkWdata_d  = bus.dd0out;
          blkWvalid_d = 1'b1;
          cnt_d       = cnt_q + CW'(1);
        end else if (blkWvalid_q) begin
          if (bus.blk_wready) blkWvalid_d = 1'b0;
        end else if (cnt_q < FULL) begin
          dd0outclk_d = 1'b1;
        end
        if (bus.blk_done || timeout) begin
          blkWr_d     = 1'b0;
          blkWvalid_d = 1'b0;
          dd0outclk_d = 1'b0;
          finish      = 1'b1;
          errNext     = timeout || bus.blk_err;
        end
      end
      ACK: begin
        if (!rdReq && !wrReq && bus.dsr[DSR_ACKACK]) state_d = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (!bus.dsr[DSR_ACKACK]) begin
          dcrFin_d = 1'b0;
          dcrErr_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A force-interrupted command still drains storage but never reports status
    if (finish) begin
      if (abort_d) begin
        state_d = IDLE;
      end else begin
        state_d  = ACK;
        dcrFin_d = 1'b1;
        dcrErr_d = errNext;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rdReqPrev_q <= 1'b0;
      wrReqPrev_q <= 1'b0;
      isRead_q    <= 1'b0;
      drive_q     <= 1'b0;
      sect_q      <= 5'd0;
      trk_q       <= 7'd0;
      side_q      <= 1'b0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      dcrFin_q    <= 1'b0;
      dcrErr_q    <= 1'b0;
      dd0in_q     <= 8'd0;
      dd0inclk_q  <= 1'b0;
      dd0outclk_q <= 1'b0;
      blkRd_q     <= 1'b0;
      blkWr_q     <= 1'b0;
      blkWvalid_q <= 1'b0;
      blkLba_q    <= 22'd0;
      blkWdata_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      rdReqPrev_q <= rdReq;
      wrReqPrev_q <= wrReq;
      isRead_q    <= isRead_d;
      drive_q     <= drive_d;
      sect_q      <= sect_d;
      trk_q       <= trk_d;
      side_q      <= side_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      dcrFin_q    <= dcrFin_d;
      dcrErr_q    <= dcrErr_d;
      dd0in_q     <= dd0in_d;
      dd0inclk_q  <= dd0inclk_d;
      dd0outclk_q <= dd0outclk_d;
      blkRd_q     <= blkRd_d;
      blkWr_q     <= blkWr_d;
      blkWvalid_q <= blkWvalid_d;
      blkLba_q    <= blkLba_d;
      blkWdata_q  <= blkWdata_d;
    end
  end

  assign bus.dcr        = {27'd0, dcrFin_q, dcrErr_q, 3'd0};
  assign bus.dd0in      = dd0in_q;
  assign bus.dd0inclk   = dd0inclk_q;
  assign bus.dd0outclk  = dd0outclk_q;
  assign bus.blk_lba    = blkLba_q;
  assign bus.blk_rd     = blkRd_q;
  assign bus.blk_wr     = blkWr_q;
  assign bus.blk_wdata  = blkWdata_q;
  assign bus.blk_wvalid = blkWvalid_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_wd_sector_bridge.sv
// Self-checking bench for wd_sector_bridge: directed commands with a byte scoreboard
// for both read and write streams, range errors, storage errors, reset and abort.
module tb_wd_sector_bridge;
  import wd_bridge_pkg::*;

  logic clk;
  logic rstn;
  wd_sector_bridge_if bif ();

  wd_sector_bridge dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bif)
  );

  int checks = 0;
  int errors = 0;
  int rdPulses = 0;
  int wrPops = 0;
  int wrHs = 0;
  bit blkReqSeen = 0;
  bit finSeen = 0;
  bit wrEnable = 0;
  bit popPending = 0;
  logic [7:0] rdQ[$];
  logic [7:0] expWrQ[$];
  logic [7:0] fifoQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller FIFO model, read/write scoreboards and activity flags
  always @(negedge clk) begin
    logic [7:0] e;
    if (popPending) begin
      void'(fifoQ.pop_front());
      popPending = 1'b0;
    end
    if (bif.dd0outclk) begin
      wrPops++;
      popPending = 1'b1;
    end
    bif.dd0out = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
    if (bif.dd0inclk) begin
      rdPulses++;
      checkOutput("dd0in pulse has queued byte", 32'(rdQ.size() != 0), 32'd1);
      if (rdQ.size() != 0) begin
        e = rdQ.pop_front();
        checkOutput("dd0in byte", {24'd0, bif.dd0in}, {24'd0, e});
      end
    end
    if (bif.blk_wvalid && bif.blk_wready) begin
      wrHs++;
      checkOutput("blk_wdata handshake has queued byte", 32'(expWrQ.size() != 0), 32'd1);
      if (expWrQ.size() != 0) begin
        e = expWrQ.pop_front();
        checkOutput("blk_wdata byte", {24'd0, bif.blk_wdata}, {24'd0, e});
      end
    end
    if (bif.blk_rd || bif.blk_wr) blkReqSeen = 1'b1;
    if (bif.dcr[DCR_FIN]) finSeen = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    bif.blk_wready = wrEnable ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation time limit");
  end

  function automatic logic [31:0] mkDsr(input int cmd, input int trk, input int side, input int sect);
    return (32'd1 << cmd) | (32'(side) << 12) | (32'(trk) << 5) | 32'(sect);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] v);
    @(posedge clk);
    #1;
    bif.dsr = v;
  endtask

  task automatic waitBlkReq(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bif.blk_rd | bif.blk_wr;
    end
    checkOutput({tag, " storage request seen"}, 32'(seen), 32'd1);
  endtask

  task automatic waitFin(input string tag, input logic [31:0] expDcr);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bif.dcr[DCR_FIN];
    end
    checkOutput({tag, " fin seen"}, 32'(seen), 32'd1);
    checkOutput({tag, " dcr"}, bif.dcr, expDcr);
  endtask

  task automatic sendBytes(input int n, input int seed);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bif.blk_rdata  = 8'(i * 7 + seed);
      bif.blk_rvalid = 1'b1;
      if (i < 512) rdQ.push_back(8'(i * 7 + seed));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        bif.blk_rvalid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    bif.blk_rvalid = 1'b0;
  endtask

  task automatic pulseDone(input logic err);
    @(posedge clk);
    #1;
    bif.blk_done = 1'b1;
    bif.blk_err  = err;
    @(posedge clk);
    #1;
    bif.blk_done = 1'b0;
    bif.blk_err  = 1'b0;
  endtask

  task automatic ackHandshake(input string tag, input logic [31:0] expDcr);
    applyStimulus(32'd1 << DSR_ACKACK);
    tick(2);
    @(negedge clk);
    checkOutput({tag, " dcr held in ack_wait"}, bif.dcr, expDcr);
    applyStimulus(32'd0);
    @(negedge clk);
    checkOutput({tag, " dcr before ack_ack fall sampled"}, bif.dcr, expDcr);
    @(negedge clk);
    checkOutput({tag, " dcr cleared"}, bif.dcr, 32'd0);
    checkOutput({tag, " busy cleared"}, 32'(bif.busy), 32'd0);
  endtask

  task automatic readSector(input string tag, input logic [31:0] dsrVal, input int expLba,
                            input int nBytes, input logic err, input logic [31:0] expDcr);
    rdPulses = 0;
    applyStimulus(dsrVal);
    waitBlkReq(tag);
    checkOutput({tag, " blk_rd"}, 32'(bif.blk_rd), 32'd1);
    checkOutput({tag, " blk_wr"}, 32'(bif.blk_wr), 32'd0);
    checkOutput({tag, " blk_lba"}, 32'(bif.blk_lba), 32'(expLba));
    sendBytes(nBytes, expLba);
    pulseDone(err);
    waitFin(tag, expDcr);
    checkOutput({tag, " dd0inclk pulses"}, 32'(rdPulses), 32'((nBytes > 512) ? 512 : nBytes));
    checkOutput({tag, " read queue drained"}, 32'(rdQ.size()), 32'd0);
    ackHandshake(tag, expDcr);
  endtask

  task automatic writeSector(input string tag, input logic [31:0] dsrVal, input int expLba);
    bit done = 1'b0;
    for (int k = 0; k < 512; k++) begin
      fifoQ.push_back(8'(k));
      expWrQ.push_back(8'(k));
    end
    wrPops   = 0;
    wrHs     = 0;
    wrEnable = 1'b1;
    applyStimulus(dsrVal);
    waitBlkReq(tag);
    checkOutput({tag, " blk_wr"}, 32'(bif.blk_wr), 32'd1);
    checkOutput({tag, " blk_lba"}, 32'(bif.blk_lba), 32'(expLba));
    for (int i = 0; i < 8000 && !done; i++) begin
      @(negedge clk);
      done = (wrHs >= 512);
    end
    checkOutput({tag, " handshakes within budget"}, 32'(wrHs), 32'd512);
    tick(8);
    checkOutput({tag, " dd0outclk pulses"}, 32'(wrPops), 32'd512);
    checkOutput({tag, " blk_wvalid idle after sector"}, 32'(bif.blk_wvalid), 32'd0);
    wrEnable = 1'b0;
    pulseDone(1'b0);
    waitFin(tag, 32'h10);
    checkOutput({tag, " fifo drained"}, 32'(fifoQ.size()), 32'd0);
    checkOutput({tag, " write queue drained"}, 32'(expWrQ.size()), 32'd0);
    ackHandshake(tag, 32'h10);
  endtask

  task automatic rangeErr(input string tag, input logic [31:0] dsrVal);
    blkReqSeen = 1'b0;
    applyStimulus(dsrVal);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " dcr within 2 cycles"}, bif.dcr, 32'h18);
    ackHandshake(tag, 32'h18);
    checkOutput({tag, " no storage access"}, 32'(blkReqSeen), 32'd0);
  endtask

  initial begin
    rstn           = 1'b0;
    bif.dsr        = 32'd0;
    bif.blk_rdata  = 8'd0;
    bif.blk_rvalid = 1'b0;
    bif.blk_done   = 1'b0;
    bif.blk_err    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset dcr", bif.dcr, 32'd0);
    checkOutput("reset busy", 32'(bif.busy), 32'd0);
    checkOutput("reset blk_rd/wr", {30'd0, bif.blk_rd, bif.blk_wr}, 32'd0);
    checkOutput("reset blk_lba", 32'(bif.blk_lba), 32'd0);
    checkOutput("reset strobes", {29'd0, bif.dd0inclk, bif.dd0outclk, bif.blk_wvalid}, 32'd0);
    tick(1);
    rstn = 1'b1;
    tick(2);

    $display("[TB] read drive0 t2 s1 sec3");
    readSector("rd52", mkDsr(DSR_RD0, 2, 1, 3), 52, 512, 1'b0, 32'h10);

    $display("[TB] simultaneous read+write request, read wins");
    readSector("prio", mkDsr(DSR_RD0, 0, 0, 2) | (32'd1 << DSR_WR1), 1, 512, 1'b0, 32'h10);

    $display("[TB] write drive1 t0 s0 sec1");
    writeSector("wr1600", mkDsr(DSR_WR1, 0, 0, 1), 1600);

    $display("[TB] out-of-range commands");
    rangeErr("sect0", mkDsr(DSR_RD0, 0, 0, 0));
    rangeErr("sect11", mkDsr(DSR_WR1, 5, 0, 11));
    rangeErr("trk80", mkDsr(DSR_RD1, 80, 0, 1));

    $display("[TB] storage error and short read");
    readSector("rderr", mkDsr(DSR_RD1, 79, 1, 10), 3199, 512, 1'b1, 32'h18);
    readSector("short", mkDsr(DSR_RD0, 0, 0, 10), 9, 100, 1'b0, 32'h18);

    $display("[TB] reset mid-read");
    applyStimulus(mkDsr(DSR_RD0, 3, 0, 4));
    waitBlkReq("rstmid");
    sendBytes(50, 11);
    rstn           = 1'b0;
    bif.dsr        = 32'd0;
    bif.blk_rvalid = 1'b0;
    #1;
    checkOutput("rstmid blk_rd", 32'(bif.blk_rd), 32'd0);
    checkOutput("rstmid dcr", bif.dcr, 32'd0);
    checkOutput("rstmid busy", 32'(bif.busy), 32'd0);
    checkOutput("rstmid dd0inclk", 32'(bif.dd0inclk), 32'd0);
    checkOutput("rstmid blk_lba", 32'(bif.blk_lba), 32'd0);
    rdQ.delete();
    tick(2);
    rstn = 1'b1;
    tick(2);
    readSector("after_rst", mkDsr(DSR_RD0, 1, 0, 5), 24, 512, 1'b0, 32'h10);

    $display("[TB] request dropped mid-read");
    finSeen = 1'b0;
    applyStimulus(mkDsr(DSR_RD0, 4, 1, 6));
    waitBlkReq("abort");
    sendBytes(100, 3);
    applyStimulus(32'd0);
    sendBytes(20, 9);
    pulseDone(1'b0);
    @(negedge clk);
    checkOutput("abort busy after done", 32'(bif.busy), 32'd0);
    checkOutput("abort blk_rd released", 32'(bif.blk_rd), 32'd0);
    tick(5);
    checkOutput("abort no fin pulse", 32'(finSeen), 32'd0);
    checkOutput("abort dcr", bif.dcr, 32'd0);
    rdQ.delete();

    $display("[TB] read after abort");
    readSector("post_abort", mkDsr(DSR_RD1, 0, 1, 1), 1610, 512, 1'b0, 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
